// File: rtl/packet_streamer_pkg.sv
// Shared definitions for the packet streamer: FSM encoding, byte sizing and
// the word-count helper used when a descriptor is accepted.
package packet_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned BITS_PER_BYTE      = 8;
    localparam int unsigned DEF_DATA_BITS      = 512;
    localparam int unsigned DEF_BYTES_PER_WORD = DEF_DATA_BITS / BITS_PER_BYTE;

    function automatic int unsigned bytes_per_word(input int unsigned data_bits);
        return data_bits / BITS_PER_BYTE;
    endfunction

    // ceil(len / bytes); 32-bit arithmetic so len + bytes - 1 cannot wrap.
    function automatic logic [31:0] words_for_len(input logic [31:0] len,
                                                  input logic [31:0] bytes);
        return (len + bytes - 32'd1) / bytes;
    endfunction

endpackage

// File: rtl/packet_streamer_if.sv
// Descriptor, upstream-buffer and AXI-Stream signals of the packet streamer,
// with a master view for the streamer and a slave view for its environment.
interface packet_streamer_if #(
    parameter int DATA_BITS = 512,
    parameter int LEN_BITS  = 16
);
    logic                   desc_valid;
    logic                   desc_ready;
    logic [LEN_BITS-1:0]    desc_len;

    logic                   up_empty;
    logic                   up_rd_en;
    logic [DATA_BITS-1:0]   up_rdata;

    logic [DATA_BITS-1:0]   m_axis_tdata;
    logic [DATA_BITS/8-1:0] m_axis_tkeep;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   m_axis_tlast;

    logic                   pkt_done;
    logic                   err_zero_len;

    modport master (
        input  desc_valid, desc_len, up_empty, up_rdata, m_axis_tready,
        output desc_ready, up_rd_en, m_axis_tdata, m_axis_tkeep,
               m_axis_tvalid, m_axis_tlast, pkt_done, err_zero_len
    );

    modport slave (
        output desc_valid, desc_len, up_empty, up_rdata, m_axis_tready,
        input  desc_ready, up_rd_en, m_axis_tdata, m_axis_tkeep,
               m_axis_tvalid, m_axis_tlast, pkt_done, err_zero_len
    );

endinterface

// File: rtl/packet_streamer_skid_fifo.sv
// Output skid FIFO holding stream beats (data, keep, last); outputs read as
// zero whenever the FIFO is empty so reset leaves the stream bus quiet.
module stream_skid_fifo #(
    parameter  int DATA_BITS = 512,
    parameter  int DEPTH     = 4,
    localparam int KEEP_W    = DATA_BITS / 8,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] push_data_i,
    input  logic [KEEP_W-1:0]    push_keep_i,
    input  logic                 push_last_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic [KEEP_W-1:0]    keep_o,
    output logic                 last_o,
    output logic                 valid_o,
    output logic [CNT_W-1:0]     count_o
);

    logic [DATA_BITS-1:0] data_mem [DEPTH];
    logic [KEEP_W-1:0]    keep_mem [DEPTH];
    logic                 last_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             pop_ok;

    assign valid_o = (count_q != '0);
    assign pop_ok  = pop_i && valid_o;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            data_mem[wr_ptr_q] <= push_data_i;
            keep_mem[wr_ptr_q] <= push_keep_i;
            last_mem[wr_ptr_q] <= push_last_i;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o = valid_o ? data_mem[rd_ptr_q] : '0;
    assign keep_o = valid_o ? keep_mem[rd_ptr_q] : '0;
    assign last_o = valid_o ? last_mem[rd_ptr_q] : 1'b0;

endmodule

// File: rtl/packet_streamer.sv
// Turns one length descriptor into a packet of AXI-Stream beats read word by
// word from an upstream buffer, with credit-based flow into an output skid FIFO.
module packet_streamer
    import packet_streamer_pkg::*;
#(
    parameter int DATA_BITS  = 512,
    parameter int LEN_BITS   = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    packet_streamer_if.master bus
);

    localparam int BYTES  = int'(bytes_per_word(DATA_BITS));
    localparam int KEEP_W = BYTES;
    localparam int CNT_W  = $clog2(SKID_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(SKID_DEPTH);

    state_e              state_q, state_d;
    logic [LEN_BITS-1:0] words_total_q, words_total_d;
    logic [LEN_BITS-1:0] tail_q, tail_d;
    logic [LEN_BITS-1:0] words_req_q, words_req_d;
    logic [LEN_BITS-1:0] beats_pushed_q, beats_pushed_d;
    logic                in_flight_q, in_flight_d;
    logic                err_q, err_d;
    logic                desc_ready_q, desc_ready_d;
    logic                rd_en;

    logic                push, push_last, pop;
    logic [KEEP_W-1:0]   push_keep;
    logic                skid_valid, skid_last;
    logic [CNT_W-1:0]    skid_count;
    logic [CNT_W:0]      occupancy;
    logic                credit_ok;

    // tail == 0 means the final word is full.
    function automatic logic [KEEP_W-1:0] keep_for_tail(input logic [LEN_BITS-1:0] tail);
        logic [KEEP_W-1:0] k;
        k = '1;
        if (tail != '0) begin
            for (int i = 0; i < KEEP_W; i++) begin
                k[i] = (i < int'(tail));
            end
        end
        return k;
    endfunction

    // The upstream word arrives the cycle after the read, so the push
    // is just the delayed read strobe.
    assign push      = in_flight_q;
    assign push_last = ((beats_pushed_q + LEN_BITS'(1)) == words_total_q);
    assign push_keep = push_last ? keep_for_tail(tail_q) : '1;
    assign pop       = skid_valid && bus.m_axis_tready;

    assign occupancy = {1'b0, skid_count} + {{CNT_W{1'b0}}, in_flight_q};
    assign credit_ok = (occupancy < DEPTH_V);

    stream_skid_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (bus.up_rdata),
        .push_keep_i (push_keep),
        .push_last_i (push_last),
        .pop_i       (pop),
        .data_o      (bus.m_axis_tdata),
        .keep_o      (bus.m_axis_tkeep),
        .last_o      (skid_last),
        .valid_o     (skid_valid),
        .count_o     (skid_count)
    );

    always_comb begin
        state_d        = state_q;
        words_total_d  = words_total_q;
        tail_d         = tail_q;
        words_req_d    = words_req_q;
        beats_pushed_d = push ? beats_pushed_q + LEN_BITS'(1) : beats_pushed_q;
        err_d          = 1'b0;
        rd_en          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.desc_valid && desc_ready_q) begin
                    if (bus.desc_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        words_total_d  = LEN_BITS'(words_for_len(32'(bus.desc_len), 32'(BYTES)));
                        tail_d         = LEN_BITS'(32'(bus.desc_len) % 32'(BYTES));
                        words_req_d    = '0;
                        beats_pushed_d = '0;
                        state_d        = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (!bus.up_empty && (words_req_q < words_total_q) && credit_ok) begin
                    rd_en       = 1'b1;
                    words_req_d = words_req_q + LEN_BITS'(1);
                end
                if (words_req_d == words_total_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && skid_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        desc_ready_d = (state_d == ST_IDLE);
        in_flight_d  = rd_en;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            words_total_q  <= '0;
            tail_q         <= '0;
            words_req_q    <= '0;
            beats_pushed_q <= '0;
            in_flight_q    <= 1'b0;
            err_q          <= 1'b0;
            desc_ready_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            words_total_q  <= words_total_d;
            tail_q         <= tail_d;
            words_req_q    <= words_req_d;
            beats_pushed_q <= beats_pushed_d;
            in_flight_q    <= in_flight_d;
            err_q          <= err_d;
            desc_ready_q   <= desc_ready_d;
        end
    end

    assign bus.desc_ready    = desc_ready_q;
    assign bus.up_rd_en      = rd_en;
    assign bus.m_axis_tvalid = skid_valid;
    assign bus.m_axis_tlast  = skid_last;
    assign bus.pkt_done      = pop && skid_last;
    assign bus.err_zero_len  = err_q;

endmodule

// File: tb/tb_packet_streamer.sv
// Directed bench for packet_streamer: upstream word model, negedge beat
// monitor, and a linear sequence of packet scenarios with immediate asserts.
module tb_packet_streamer;

    localparam int DATA_BITS  = 512;
    localparam int LEN_BITS   = 16;
    localparam int SKID_DEPTH = 4;
    localparam logic [511:0] KEEP_ALL = {448'd0, {64{1'b1}}};

    logic clk;
    logic resetn;

    packet_streamer_if #(.DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) bus ();

    packet_streamer #(
        .DATA_BITS  (DATA_BITS),
        .LEN_BITS   (LEN_BITS),
        .SKID_DEPTH (SKID_DEPTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int cyc = 0, words_sent = 0;
    bit rd_pend = 1'b0;
    int req_cnt = 0, pop_cnt = 0, rd_en_cnt = 0, credit_viol = 0;
    int tv_cycles = 0, stall_viol = 0, stall_cycles = 0;
    int err_cycles = 0, done_cnt = 0, ready_low = 0;
    int accept_cyc = 0, first_tv_cyc = 0;
    bit tv_seen = 1'b0, stalled_prev = 1'b0;
    logic [511:0] prev_data;
    logic [63:0]  prev_keep;
    logic         prev_last;

    logic [511:0] q_data[$];
    logic [63:0]  q_keep[$];
    bit           q_last[$];
    bit           q_done[$];
    int           q_cyc[$];

    function automatic logic [511:0] make_word(input int idx);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(idx);
        return {16{w}};
    endfunction

    // Upstream buffer: a word appears one cycle after each read strobe.
    always @(posedge clk) begin
        cyc++;
        if (rd_pend) begin
            bus.up_rdata <= make_word(words_sent);
            words_sent++;
        end
    end

    always @(negedge clk) begin
        if (!resetn) req_cnt = pop_cnt;
        if (bus.up_rd_en) begin
            rd_en_cnt++;
            if (req_cnt - pop_cnt >= SKID_DEPTH) credit_viol++;
            req_cnt++;
        end
        if (bus.desc_valid && bus.desc_ready) begin
            accept_cyc = cyc;
            tv_seen    = 1'b0;
        end
        if (bus.m_axis_tvalid) begin
            tv_cycles++;
            if (!tv_seen) begin
                tv_seen      = 1'b1;
                first_tv_cyc = cyc;
            end
        end
        if (stalled_prev) begin
            stall_cycles++;
            if (bus.m_axis_tdata !== prev_data || bus.m_axis_tkeep !== prev_keep ||
                bus.m_axis_tlast !== prev_last) stall_viol++;
        end
        stalled_prev = resetn && bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data    = bus.m_axis_tdata;
        prev_keep    = bus.m_axis_tkeep;
        prev_last    = bus.m_axis_tlast;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            q_data.push_back(bus.m_axis_tdata);
            q_keep.push_back(bus.m_axis_tkeep);
            q_last.push_back(bus.m_axis_tlast);
            q_done.push_back(bus.pkt_done);
            q_cyc.push_back(cyc);
            pop_cnt++;
        end
        if (bus.err_zero_len) err_cycles++;
        if (bus.pkt_done) done_cnt++;
        if (resetn && !bus.desc_ready) ready_low++;
        rd_pend = bus.up_rd_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_desc(input logic [LEN_BITS-1:0] len);
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b1;
        bus.desc_len   = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.desc_ready) break;
        end
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (q_data.size() >= n) break;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_pkt(input string tag, input int b0, input int s0, input int n,
                             input logic [63:0] last_keep);
        check($sformatf("%s_beats", tag), 512'(q_data.size() - b0), 512'(n));
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_data%0d", tag, j), q_data[b0+j], make_word(s0 + j));
            check($sformatf("%s_keep%0d", tag, j), 512'(q_keep[b0+j]),
                  (j == n - 1) ? 512'(last_keep) : KEEP_ALL);
            check($sformatf("%s_last%0d", tag, j), 512'(q_last[b0+j]), 512'(j == n - 1));
            check($sformatf("%s_done%0d", tag, j), 512'(q_done[b0+j]), 512'(j == n - 1));
        end
    endtask

    initial begin
        int b0, s0, d0, e0, r0, t0, l0, sc0;

        resetn            = 1'b0;
        bus.desc_valid    = 1'b0;
        bus.desc_len      = '0;
        bus.up_empty      = 1'b0;
        bus.m_axis_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
        check("rst_tdata",  bus.m_axis_tdata, 512'(0));
        check("rst_tkeep",  512'(bus.m_axis_tkeep), 512'(0));
        check("rst_tlast",  512'(bus.m_axis_tlast), 512'(0));
        check("rst_rd_en",  512'(bus.up_rd_en), 512'(0));
        check("rst_ready",  512'(bus.desc_ready), 512'(0));
        check("rst_done",   512'(bus.pkt_done), 512'(0));
        check("rst_err",    512'(bus.err_zero_len), 512'(0));
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 512'(bus.desc_ready), 512'(1));

        // 200 bytes: 4 beats, 8-byte tail
        idle(3);
        b0 = q_data.size(); s0 = words_sent; d0 = done_cnt;
        send_desc(16'd200);
        wait_beats(b0 + 4, 40);
        idle(4);
        check_pkt("len200", b0, s0, 4, 64'h0000_0000_0000_00FF);
        check("len200_latency", 512'(first_tv_cyc - accept_cyc), 512'(3));
        check("len200_thruput", 512'(q_cyc[b0+3] - q_cyc[b0]), 512'(3));
        check("len200_done_cnt", 512'(done_cnt - d0), 512'(1));

        // 128 bytes: 2 full beats
        idle(3);
        b0 = q_data.size(); s0 = words_sent;
        send_desc(16'd128);
        wait_beats(b0 + 2, 40);
        idle(4);
        check_pkt("len128", b0, s0, 2, 64'hFFFF_FFFF_FFFF_FFFF);

        // 640 bytes with tready high one cycle in three
        idle(3);
        b0 = q_data.size(); s0 = words_sent; d0 = done_cnt; sc0 = stall_cycles;
        bus.m_axis_tready = 1'b0;
        send_desc(16'd640);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            bus.m_axis_tready = (k % 3 == 0);
            if (done_cnt > d0) break;
        end
        bus.m_axis_tready = 1'b1;
        idle(4);
        check_pkt("len640", b0, s0, 10, 64'hFFFF_FFFF_FFFF_FFFF);
        check("len640_credit_viol", 512'(credit_viol), 512'(0));
        check("len640_stall_viol", 512'(stall_viol), 512'(0));
        check("len640_stalls_seen", 512'(stall_cycles > sc0), 512'(1));

        // Zero-length descriptor
        idle(3);
        e0 = err_cycles; r0 = rd_en_cnt; t0 = tv_cycles; l0 = ready_low;
        send_desc(16'd0);
        idle(10);
        check("zero_err_pulse", 512'(err_cycles - e0), 512'(1));
        check("zero_no_rd", 512'(rd_en_cnt - r0), 512'(0));
        check("zero_no_tvalid", 512'(tv_cycles - t0), 512'(0));
        check("zero_ready_kept", 512'(ready_low - l0), 512'(0));

        // Upstream empty for 20 cycles mid-packet (512 bytes, 8 beats)
        b0 = q_data.size(); s0 = words_sent;
        send_desc(16'd512);
        wait_beats(b0 + 3, 40);
        bus.up_empty = 1'b1;
        r0 = rd_en_cnt;
        idle(20);
        check("empty_no_rd", 512'(rd_en_cnt - r0), 512'(0));
        check("empty_paused", 512'(q_data.size() - b0 < 8), 512'(1));
        bus.up_empty = 1'b0;
        wait_beats(b0 + 8, 60);
        idle(4);
        check_pkt("empty", b0, s0, 8, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset after beat 2 of an 8-beat packet
        idle(3);
        b0 = q_data.size();
        send_desc(16'd512);
        wait_beats(b0 + 2, 40);
        resetn = 1'b0;
        #1;
        check("midrst_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
        check("midrst_tdata",  bus.m_axis_tdata, 512'(0));
        check("midrst_tkeep",  512'(bus.m_axis_tkeep), 512'(0));
        check("midrst_tlast",  512'(bus.m_axis_tlast), 512'(0));
        check("midrst_rd_en",  512'(bus.up_rd_en), 512'(0));
        check("midrst_ready",  512'(bus.desc_ready), 512'(0));
        t0 = tv_cycles;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(10);
        check("midrst_beats", 512'(q_data.size() - b0), 512'(2));
        check("midrst_no_tvalid", 512'(tv_cycles - t0), 512'(0));
        b0 = q_data.size(); s0 = words_sent;
        send_desc(16'd64);
        wait_beats(b0 + 1, 40);
        idle(4);
        check_pkt("postrst", b0, s0, 1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Maximum length: 65535 bytes -> 1024 beats, 63-byte tail
        idle(3);
        b0 = q_data.size(); s0 = words_sent;
        send_desc(16'hFFFF);
        wait_beats(b0 + 1024, 1300);
        idle(4);
        check_pkt("maxlen", b0, s0, 1024, 64'h7FFF_FFFF_FFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/packet_streamer.md
PACKET_STREAMER -- requirements
Module: packet_streamer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512, upstream/stream word width.
REQ-002 SHALL have parameter LEN_BITS, default 16, packet length field width in bytes.
REQ-003 SHALL have parameter SKID_DEPTH, default 4, output skid FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports desc_valid input 1, desc_ready output 1, desc_len input LEN_BITS: packet descriptor handshake, length in bytes.
REQ-007 SHALL have port up_empty  input  1  upstream data buffer has no word.
REQ-008 SHALL have port up_rd_en  output  1  one-word read request to upstream data buffer.
REQ-009 SHALL have port up_rdata  input  DATA_BITS  upstream word, valid exactly 1 cycle after up_rd_en.
REQ-010 SHALL have ports m_axis_tdata output DATA_BITS, m_axis_tkeep output DATA_BITS/8, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: AXI-Stream master.
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse when last beat transfers.
REQ-012 SHALL have port err_zero_len  output  1  one-cycle pulse on zero-length descriptor.

Function
REQ-013 SHALL implement FSM IDLE, FETCH, DRAIN.
REQ-014 IDLE: desc_ready=1; on desc_valid&&desc_ready latch words_total=ceil(desc_len/(DATA_BITS/8)), tail=desc_len mod (DATA_BITS/8); go FETCH; desc_len=0 -> pulse err_zero_len next cycle, stay IDLE.
REQ-015 desc_ready SHALL be 0 in FETCH and DRAIN; no descriptor overlap.
REQ-016 FETCH: up_rd_en=1 only when !up_empty AND words_requested<words_total AND skid_count+in_flight<SKID_DEPTH (credit rule; skid never overflows).
REQ-017 Word returned 1 cycle after up_rd_en SHALL be pushed into skid FIFO unconditionally.
REQ-018 When words_requested reaches words_total, FSM SHALL go DRAIN; DRAIN -> IDLE on the beat with tvalid&&tready&&tlast.
REQ-019 m_axis_tvalid = skid non-empty; beat transfers on tvalid&&tready; tdata/tkeep/tlast SHALL hold stable while tvalid&&!tready.
REQ-020 tlast SHALL be 1 only on beat number words_total; its tkeep = low `tail` bytes set, all ones if tail=0; all other beats tkeep all ones.
REQ-021 Simultaneous skid push and pop SHALL keep count unchanged; pointers wrap modulo SKID_DEPTH.
REQ-022 Beat counter and words_requested SHALL be LEN_BITS wide; no overflow for desc_len=2^LEN_BITS-1.
REQ-023 Minimum latency desc accept -> first tvalid: 3 cycles (accept, rd_en, data push) with up_empty=0 and tready=1.
REQ-024 Full throughput: one beat per cycle sustained when up_empty=0 and tready=1.
REQ-025 pkt_done SHALL pulse in the same cycle as the tlast transfer.

Reset
REQ-026 On resetn=0: FSM IDLE, all counters/pointers 0, up_rd_en=0, m_axis_tvalid=0, tlast=0, tdata=0, tkeep=0, pkt_done=0, err_zero_len=0, desc_ready=0 while asserted, 1 first cycle after release.
REQ-027 Reset mid-packet SHALL discard partial packet and in-flight word; no beat emitted after release until new descriptor.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, bytes-per-word constant, and word-count function ceil(len/bytes).
REQ-029 Skid FIFO SHALL be one sub-module, stream_skid_fifo (push, pop, count, data+tlast+tkeep).

Verification
REQ-030 desc_len=200, up_empty=0, tready=1 -> 4 beats, tkeep last=0x00FF (8 bytes), tlast+pkt_done on beat 4, first tvalid 3 cycles after accept.
REQ-031 desc_len=128 -> 2 beats, both tkeep all ones, tlast on beat 2.
REQ-032 desc_len=640, tready toggled 1-of-3 -> 10 beats in order, up_rd_en never issued with skid_count+in_flight=4, data stable while stalled.
REQ-033 desc_len=0 -> err_zero_len single pulse, no up_rd_en, no tvalid, desc_ready stays 1.
REQ-034 up_empty=1 for 20 cycles mid-packet -> no up_rd_en during stall, packet resumes, correct word count.
REQ-035 resetn=0 after beat 2 of 8-beat packet -> outputs zero immediately, no further beats, next desc_len=64 yields single beat tlast=1.
